// File: rtl/host_mailbox_m.sv
// host_mailbox_m: BBC host-bus responder with a paged-ROM select shadow and a
// four-register FIFO mailbox bridging host cycles to a valid/ready side port.
module host_mailbox_m #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] MBOX_BASE   = 16'hFC00,
    parameter logic [15:0] ROMSEL_ADDR = 16'hFE30
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        phi0,
    input  logic [15:0] addr,
    input  logic        rnw,
    input  logic        sync,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [3:0]  romsel_q,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic          phi0_q, rnw_q, sync_q, sel_rom_q, sel_mb_q;
    logic [1:0]    off_q;
    logic [7:0]    wdata_q, sync_cnt;
    logic          irq_en, tx_ovf;
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          start, fin, hw, hr, tx_full, rx_ne;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    assign start    = phi0 & ~phi0_q;
    assign fin      = ~phi0 & phi0_q;
    assign hw       = fin & sel_mb_q & ~rnw_q;
    assign hr       = fin & sel_mb_q & rnw_q;
    assign tx_full  = tx_cnt == CW'(FIFO_DEPTH);
    assign rx_ne    = rx_cnt != '0;
    assign tx_valid = tx_cnt != '0;
    assign tx_data  = tx_mem[tx_rp];
    assign rx_ready = resetb & (rx_cnt != CW'(FIFO_DEPTH));
    assign irq_o    = irq_en & rx_ne;
    assign tx_push  = hw & off_q == 2'd0 & ~tx_full;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = hr & off_q == 2'd1 & rx_ne;
    assign data_oe  = phi0 & phi0_q & sel_mb_q & rnw_q;
    assign data_out = !data_oe ? 8'h00 :
                      off_q == 2'd0 ? 8'(tx_cnt) :
                      off_q == 2'd1 ? (rx_ne ? rx_mem[rx_rp] : 8'hFF) :
                      off_q == 2'd2 ? {4'b0, irq_en, tx_ovf, tx_full, rx_ne} : sync_cnt;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= wdata_q;
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    // phi0_q resets high so a PHI2 phase already running at release is never started
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            phi0_q    <= 1'b1;
            rnw_q     <= 1'b0;
            sync_q    <= 1'b0;
            sel_rom_q <= 1'b0;
            sel_mb_q  <= 1'b0;
            off_q     <= '0;
            wdata_q   <= '0;
            romsel_q  <= '0;
            irq_en    <= 1'b0;
            tx_ovf    <= 1'b0;
            sync_cnt  <= '0;
            tx_wp     <= '0;
            tx_rp     <= '0;
            rx_wp     <= '0;
            rx_rp     <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
        end else begin
            phi0_q <= phi0;
            if (start) begin
                off_q     <= addr[1:0];
                rnw_q     <= rnw;
                sync_q    <= sync;
                sel_rom_q <= addr == ROMSEL_ADDR;
                sel_mb_q  <= addr[15:2] == MBOX_BASE[15:2];
            end
            if (phi0) wdata_q <= data_in;
            if (fin & sel_rom_q & ~rnw_q) romsel_q <= wdata_q[3:0];
            if (hw & off_q == 2'd0 & tx_full) tx_ovf <= 1'b1;
            if (hw & off_q == 2'd2) begin
                irq_en <= wdata_q[3];
                if (wdata_q[2]) tx_ovf <= 1'b0;
            end
            if (hw & off_q == 2'd3) sync_cnt <= '0;
            else if (fin & sync_q) sync_cnt <= sync_cnt + 8'd1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
endmodule

// File: doc/host_mailbox_m.md
# host_mailbox_m

Responder for the BBC host bus, clocked from bbc_ck8. It decodes host cycles issued by the accelerator CPLD: bbc_addr, bbc_rnw, bbc_sync, data during bbc_ck2 PHI2. It implements a write-only shadow of the paged-ROM select register at FE30, plus a four-register mailbox in the FRED page. The mailbox contains two byte FIFOs bridging host cycles to a valid/ready side port, and a sync-cycle counter.

## Interface
- FIFO_DEPTH, 4, entries per FIFO; power of two, 2..16.
- MBOX_BASE, 16'hFC00, mailbox base; decoded on addr[15:2].
- ROMSEL_ADDR, 16'hFE30, paged-ROM select address; full 16-bit decode.

Ports:
- clk  in  1  bbc_ck8 (8MHz); all flops rise on clk.
- resetb  in  1  reset, asynchronous, active-low.
- phi0  in  1  bbc_ck2_phi0; high = PHI2 phase; synchronous to clk (4 clk per host cycle).
- addr  in  16  host address.
- rnw  in  1  host read-not-write.
- sync  in  1  host sync (opcode fetch).
- data_in  in  8  host data bus, write direction.
- data_out  out  8  read data.
- data_oe  out  1  drive enable for data_out.
- romsel_q  out  4  shadow ROM select.
- tx_data  out  8  head of host→side FIFO.
- tx_valid  out  1  tx FIFO non-empty.
- tx_ready  in  1  side consumer accepts.
- rx_data  in  8  side→host byte.
- rx_valid  in  1  side producer offers.
- rx_ready  out  1  rx FIFO not full; 0 while resetb low.
- irq_o  out  1  = irq_en & rx non-empty; active high; board inverts to irqb.

## Operation
- phi0_q registers phi0; start = phi0 & !phi0_q; end = !phi0 & phi0_q.
- At start: latch addr, rnw, sync into the cycle registers; sel_rom = addr==ROMSEL_ADDR; sel_mb = addr[15:2]==MBOX_BASE[15:2].
- Every clk with phi0 high: capture data_in into wdata_q. The last capture before end is the write data.
- All side effects (register writes, FIFO push/pop, counter update) commit on the end clk.
- Register map (offset = latched addr[1:0]):
  - +0 W: push wdata_q to tx FIFO. If full, drop the byte and set tx_ovf. R: {4'b0, tx level}.
  - +1 R: rx head. Pop at end if non-empty. Empty returns 8'hFF with no pop. W: ignored.
  - +2 R status: [0] rx non-empty, [1] tx full, [2] tx_ovf sticky, [3] irq_en, [7:4] 0. W: bit3 → irq_en; bit2=1 clears tx_ovf.
  - +3 R: sync_cnt. W: clear sync_cnt to 0 (data ignored).
- ROMSEL_ADDR: write sets romsel_q = wdata_q[3:0]. Reads are not decoded; data_oe stays 0.
- data_oe = phi0 & phi0_q & sel_mb & rnw_latched. data_out is combinational from latched offset and current state; it is 0 when data_oe is low.
- sync_cnt: 8-bit, +1 at end when sync_latched=1, wraps 255→0. A write to +3 in the same cycle wins (result 0).
- Side tx: pop on clk with tx_valid & tx_ready.
- Side rx: push on clk with rx_valid & rx_ready; rx_ready = !rx_full.
- Simultaneous host and side FIFO ops on the same clk both apply; the level updates by net change.
- Full/empty flags come from registered counts. A host push to a full tx FIFO is dropped even if the side pops on the same clk.

## Timing
- Reset values: romsel_q 0, irq_en 0, tx_ovf 0, sync_cnt 0, both FIFOs empty, tx_valid 0, irq_o 0, data_oe 0, rx_ready 0 while in reset.
- phi0_q resets to 1, so a PHI2 phase already in progress at reset release is ignored.
- Read data valid one clk after phi0 rises; held until phi0 falls.
- Status/FIFO effects of host cycle N are visible to cycle N+1 and on the side port one clk after end.
- rx push to irq_o high: 1 clk.
- Reset asserted mid-cycle aborts the cycle with no commit.

## Test plan
- Reset: after release, expect romsel_q=0, data_oe=0, tx_valid=0, rx_ready=1, status read returns 8'h00.
- Write 8'h0B to FE30 → romsel_q=4'hB at end. Read FE30 → data_oe stays 0.
- Five writes (8'h11..8'h15) to FC00 with tx_ready=0 → four accepted, status=8'h06. Then raise tx_ready → tx_data 8'h11..8'h14 on consecutive clks.
- Side pushes 8'hA5 with irq_en set via FC02=8'h08 → irq_o=1 one clk later. Read FC01 → 8'hA5, irq_o drops after end. Second read FC01 → 8'hFF.
- 300 cycles with sync=1, then read FC03 → 8'h2C (300 mod 256). Write FC03 with sync=1 in the same cycle → next read 8'h00.
- Side pop and host push to a 3-deep tx FIFO in the same clk → level stays 3. Assert resetb low mid-PHI2 during a FC00 write → no push, all outputs at reset values.
